// File: rtl/ysyx_22051013_lsu_pkg.sv
// Shared encodings and widths for the pip_cpu load/store unit.
// Holds memory size codes, write-back selects and LSU FSM states.
package ysyx_22051013_lsu_pkg;

  localparam int XLEN    = 64;
  localparam int ILEN    = 32;
  localparam int RADDR_W = 5;

  localparam int DATA    = XLEN;
  localparam int PC      = XLEN;
  localparam int INST    = ILEN;
  localparam int REGADDR = RADDR_W;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_EXU  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10,
    S_OUT  = 2'b11
  } state_e;

  function automatic logic [7:0] size_mask(size_e s);
    logic [7:0] m;
    m = 8'h01;
    unique case (s)
      SZ_B: m = 8'h01;
      SZ_H: m = 8'h03;
      SZ_W: m = 8'h0F;
      SZ_D: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ysyx_22051013_lsu_if.sv
// Data-memory bus: single-outstanding req/gnt request channel
// plus an rvalid-qualified read response.
interface ysyx_22051013_lsu_if #(
  parameter int XLEN = 64
);

  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic [7:0]      dmem_wstrb;
  logic            dmem_gnt;
  logic            dmem_rvalid;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    output dmem_wstrb,
    input  dmem_gnt,
    input  dmem_rvalid,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    input  dmem_wstrb,
    output dmem_gnt,
    output dmem_rvalid,
    output dmem_rdata
  );

endinterface

// File: rtl/ysyx_22051013_lsu_align.sv
// Byte-lane steering for the LSU: store strobes/data, load
// extraction with sign/zero extension, and misalignment detect.
module ysyx_22051013_lsu_align
  import ysyx_22051013_lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      off,
  input  size_e           size,
  input  logic            uns,
  input  logic [XLEN-1:0] st_data,
  input  logic [XLEN-1:0] rdata,
  output logic [7:0]      wstrb,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] ld_data,
  output logic            misalign
);

  logic [5:0]      sh;
  logic [XLEN-1:0] lane;

  assign sh    = {off, 3'b000};
  assign wstrb = size_mask(size) << off;
  assign wdata = st_data << sh;
  assign lane  = rdata >> sh;

  always_comb begin
    misalign = 1'b0;
    ld_data  = lane;
    unique case (size)
      SZ_B: begin
        ld_data = {{(XLEN-8){~uns & lane[7]}}, lane[7:0]};
      end
      SZ_H: begin
        misalign = off[0];
        ld_data  = {{(XLEN-16){~uns & lane[15]}}, lane[15:0]};
      end
      SZ_W: begin
        misalign = |off[1:0];
        ld_data  = {{(XLEN-32){~uns & lane[31]}}, lane[31:0]};
      end
      SZ_D: begin
        misalign = |off;
        ld_data  = lane;
      end
    endcase
  end

endmodule

// File: rtl/ysyx_22051013_lsu.sv
// Memory-access stage of pip_cpu: takes EXU bundles, runs one
// data-memory transaction at a time, hands results to WBU.
module ysyx_22051013_lsu
  import ysyx_22051013_lsu_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int ILEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_valid,
  output logic               ls_ready,
  input  logic [XLEN-1:0]    exu_res,
  input  logic [XLEN-1:0]    st_data,
  input  logic               mem_rd,
  input  logic               mem_wr,
  input  logic [1:0]         mem_size,
  input  logic               mem_uns,
  input  logic [1:0]         wb_ctl_i,
  input  logic               rd_ena_i,
  input  logic [RADDR_W-1:0] rd_addr_i,
  input  logic [XLEN-1:0]    pc_i,
  input  logic [ILEN-1:0]    inst_i,
  ysyx_22051013_lsu_if.master bus,
  output logic               ls_valid,
  input  logic               wb_ready,
  output logic [XLEN-1:0]    ls_rd_data,
  output logic [XLEN-1:0]    exu_res_o,
  output logic [1:0]         wb_ctl_o,
  output logic               rd_ena_o,
  output logic [RADDR_W-1:0] rd_addr_o,
  output logic [XLEN-1:0]    pc_o,
  output logic [ILEN-1:0]    inst_o,
  output logic               ls_misalign
);

  state_e          state;
  state_e          state_nx;
  logic            in_wait;
  logic            accept;
  logic            is_mem;
  logic            is_st;
  logic            mis;
  logic            go_bus;

  logic [2:0]      a_off;
  size_e           a_size;
  logic            a_uns;
  logic [7:0]      a_wstrb;
  logic [XLEN-1:0] a_wdata;
  logic [XLEN-1:0] a_ld;
  logic            a_mis;

  size_e           size_q;
  logic            uns_q;
  logic            we_q;
  logic [7:0]      wstrb_q;
  logic [XLEN-1:0] wdata_q;

  // Aligner sees the incoming bundle, except in WAIT where it
  // extracts load data using the latched offset and size.
  assign in_wait = (state == S_WAIT);
  assign a_off   = in_wait ? exu_res_o[2:0] : exu_res[2:0];
  assign a_size  = in_wait ? size_q : size_e'(mem_size);
  assign a_uns   = in_wait ? uns_q : mem_uns;

  ysyx_22051013_lsu_align #(
    .XLEN(XLEN)
  ) u_align (
    .off     (a_off),
    .size    (a_size),
    .uns     (a_uns),
    .st_data (st_data),
    .rdata   (bus.dmem_rdata),
    .wstrb   (a_wstrb),
    .wdata   (a_wdata),
    .ld_data (a_ld),
    .misalign(a_mis)
  );

  assign is_mem   = mem_rd | mem_wr;
  assign is_st    = mem_wr & ~mem_rd;
  assign mis      = is_mem & a_mis;
  assign ls_valid = (state == S_OUT);
  assign ls_ready = (state == S_IDLE) | (ls_valid & wb_ready);
  assign accept   = ex_valid & ls_ready;
  assign go_bus   = accept & is_mem & ~mis;

  assign bus.dmem_req   = (state == S_REQ);
  assign bus.dmem_we    = we_q;
  assign bus.dmem_addr  = {exu_res_o[XLEN-1:3], 3'b000};
  assign bus.dmem_wdata = wdata_q;
  assign bus.dmem_wstrb = wstrb_q;

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE, S_OUT: begin
        if (accept)
          state_nx = go_bus ? S_REQ : S_OUT;
        else if (ls_valid && wb_ready)
          state_nx = S_IDLE;
      end
      S_REQ: begin
        if (bus.dmem_gnt)
          state_nx = we_q ? S_OUT : S_WAIT;
      end
      S_WAIT: begin
        if (bus.dmem_rvalid)
          state_nx = S_OUT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      exu_res_o   <= '0;
      wb_ctl_o    <= '0;
      rd_ena_o    <= 1'b0;
      rd_addr_o   <= '0;
      pc_o        <= '0;
      inst_o      <= '0;
      ls_misalign <= 1'b0;
      ls_rd_data  <= '0;
      size_q      <= SZ_B;
      uns_q       <= 1'b0;
      we_q        <= 1'b0;
      wstrb_q     <= '0;
      wdata_q     <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        exu_res_o   <= exu_res;
        wb_ctl_o    <= wb_ctl_i;
        rd_ena_o    <= rd_ena_i & ~mis;
        rd_addr_o   <= rd_addr_i;
        pc_o        <= pc_i;
        inst_o      <= inst_i;
        ls_misalign <= mis;
        ls_rd_data  <= '0;
        size_q      <= size_e'(mem_size);
        uns_q       <= mem_uns;
        we_q        <= go_bus & is_st;
        wstrb_q     <= (go_bus & is_st) ? a_wstrb : '0;
        wdata_q     <= (go_bus & is_st) ? a_wdata : '0;
      end else if (in_wait && bus.dmem_rvalid) begin
        ls_rd_data <= a_ld;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22051013_lsu.sv
// Scoreboard bench for the LSU: stimulus pushes expected bundles,
// a monitor pops them on every WBU handshake.
module tb_ysyx_22051013_lsu;

  typedef struct packed {
    logic [63:0] rdd;
    logic [63:0] exu;
    logic [1:0]  wb;
    logic        ena;
    logic [4:0]  rda;
    logic [63:0] pc;
    logic [31:0] inst;
    logic        mis;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid, ls_ready;
  logic [63:0] exu_res, st_data;
  logic        mem_rd, mem_wr, mem_uns;
  logic [1:0]  mem_size, wb_ctl_i;
  logic        rd_ena_i;
  logic [4:0]  rd_addr_i;
  logic [63:0] pc_i;
  logic [31:0] inst_i;
  logic        ls_valid, wb_ready;
  logic [63:0] ls_rd_data, exu_res_o, pc_o;
  logic [1:0]  wb_ctl_o;
  logic        rd_ena_o, ls_misalign;
  logic [4:0]  rd_addr_o;
  logic [31:0] inst_o;

  int tests = 0;
  int fails = 0;
  exp_t q[$];

  int          gnt_dly = 0;
  int          rv_dly = 1;
  logic [63:0] mem_rdata = '0;
  bit          force_rv = 0;

  bit          chk_bus = 0;
  logic [63:0] exp_addr, exp_wdata;
  logic [7:0]  exp_wstrb;
  logic        exp_we;
  int          req_cycles = 0;
  int          run = 0;
  int          max_run = 0;
  logic [63:0] pc_n = 64'h8000_0000;

  always #5 clk = ~clk;

  ysyx_22051013_lsu_if #(.XLEN(64)) bus();

  ysyx_22051013_lsu #(
    .XLEN(64), .ILEN(32), .RADDR_W(5)
  ) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ls_ready(ls_ready),
    .exu_res(exu_res), .st_data(st_data),
    .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_size(mem_size), .mem_uns(mem_uns),
    .wb_ctl_i(wb_ctl_i), .rd_ena_i(rd_ena_i),
    .rd_addr_i(rd_addr_i), .pc_i(pc_i), .inst_i(inst_i),
    .bus(bus),
    .ls_valid(ls_valid), .wb_ready(wb_ready),
    .ls_rd_data(ls_rd_data), .exu_res_o(exu_res_o),
    .wb_ctl_o(wb_ctl_o), .rd_ena_o(rd_ena_o),
    .rd_addr_o(rd_addr_o), .pc_o(pc_o), .inst_o(inst_o),
    .ls_misalign(ls_misalign)
  );

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  // Memory responder: gnt after gnt_dly request cycles, rvalid rv_dly cycles after gnt.
  initial begin
    int gcnt, rcnt;
    bit rv_pend;
    gcnt = 0; rcnt = 0; rv_pend = 0;
    bus.dmem_gnt = 1'b0;
    bus.dmem_rvalid = 1'b0;
    bus.dmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.dmem_gnt = 1'b0;
      bus.dmem_rvalid = force_rv;
      bus.dmem_rdata = mem_rdata;
      if (!rst) begin
        rv_pend = 0;
        gcnt = 0;
      end else begin
        if (rv_pend) begin
          rcnt++;
          if (rcnt >= rv_dly) begin
            bus.dmem_rvalid = 1'b1;
            rv_pend = 0;
          end
        end
        if (bus.dmem_req) begin
          if (gcnt >= gnt_dly) begin
            bus.dmem_gnt = 1'b1;
            gcnt = 0;
            if (!bus.dmem_we) begin
              rv_pend = 1;
              rcnt = 0;
            end
          end else begin
            gcnt++;
          end
        end
      end
    end
  end

  // Monitor
  initial begin
    exp_t e, a;
    bit st_gnt;
    st_gnt = 0;
    forever begin
      @(negedge clk);
      if (bus.dmem_req) begin
        req_cycles++;
        if (chk_bus) begin
          chk("bus_addr", bus.dmem_addr, exp_addr);
          chk("bus_we", bus.dmem_we, exp_we);
          chk("bus_wdata", bus.dmem_wdata, exp_wdata);
          chk("bus_wstrb", bus.dmem_wstrb, exp_wstrb);
        end
      end
      if (st_gnt) chk("st_valid_after_gnt", ls_valid, 1);
      st_gnt = bus.dmem_req && bus.dmem_gnt && bus.dmem_we;
      if (ls_valid) run++;
      else run = 0;
      if (run > max_run) max_run = run;
      if (ls_valid && wb_ready && rst) begin
        a.rdd = ls_rd_data; a.exu = exu_res_o; a.wb = wb_ctl_o;
        a.ena = rd_ena_o; a.rda = rd_addr_o; a.pc = pc_o;
        a.inst = inst_o; a.mis = ls_misalign;
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_out: got exu=%h pc=%h want none", a.exu, a.pc);
        end else begin
          e = q.pop_front();
          if (a !== e) begin
            fails++;
            $display("FAIL out pc=%h: got rdd=%h exu=%h wb=%b ena=%b rd=%0d inst=%h mis=%b want rdd=%h exu=%h wb=%b ena=%b rd=%0d inst=%h mis=%b",
              e.pc, a.rdd, a.exu, a.wb, a.ena, a.rda, a.inst, a.mis,
              e.rdd, e.exu, e.wb, e.ena, e.rda, e.inst, e.mis);
          end
        end
      end
    end
  end

  task automatic drive_in(input logic [63:0] res, sd, input logic rd, wr,
                          input logic [1:0] sz, input logic uns,
                          input logic [1:0] wbc, input logic ena,
                          input logic [4:0] rda);
    exu_res = res; st_data = sd; mem_rd = rd; mem_wr = wr;
    mem_size = sz; mem_uns = uns; wb_ctl_i = wbc;
    rd_ena_i = ena; rd_addr_i = rda; pc_i = pc_n; inst_i = 32'h0000_3003;
  endtask

  function automatic exp_t mk(input logic [63:0] res, input logic [1:0] wbc,
                              input logic ena, input logic [4:0] rda,
                              input logic [63:0] rdd, input logic mis);
    exp_t e;
    e.rdd = rdd; e.exu = res; e.wb = wbc; e.ena = ena & ~mis;
    e.rda = rda; e.pc = pc_n; e.inst = 32'h0000_3003; e.mis = mis;
    return e;
  endfunction

  task automatic send(input logic [63:0] res, sd, input logic rd, wr,
                      input logic [1:0] sz, input logic uns,
                      input logic [1:0] wbc, input logic ena,
                      input logic [4:0] rda, input logic [63:0] rdd,
                      input logic mis);
    int n;
    n = 0;
    drive_in(res, sd, rd, wr, sz, uns, wbc, ena, rda);
    ex_valid = 1'b1;
    #1;
    while (!ls_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!ls_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: got ls_ready=0 want 1 pc=%h", pc_n);
    end else begin
      q.push_back(mk(res, wbc, ena, rda, rdd, mis));
    end
    @(posedge clk); #1;
    ex_valid = 1'b0;
    pc_n = pc_n + 4;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk); n++;
    end
    if (q.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain: got %0d pending want 0", q.size());
      q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic mem_op(input string name, input logic [63:0] addr, sd,
                        input logic rd, wr, input logic [1:0] sz,
                        input logic uns, input int gd, rvd,
                        input logic [63:0] rdata, rdd,
                        input logic [7:0] ws, input logic [63:0] wd,
                        input logic mis, input int nreq);
    mem_rdata = rdata; gnt_dly = gd; rv_dly = rvd;
    exp_addr = {addr[63:3], 3'b000}; exp_we = wr & ~rd;
    exp_wstrb = ws; exp_wdata = wd;
    chk_bus = 1; req_cycles = 0;
    send(addr, sd, rd, wr, sz, uns, rd ? 2'b01 : 2'b00, rd, 5'd7, rdd, mis);
    wait_drain();
    chk_bus = 0;
    chk({name, "_req_cycles"}, req_cycles, nreq);
  endtask

  localparam logic [63:0] R = 64'h8899_AABB_CCDD_EEFF;

  initial begin
    int n;
    ex_valid = 0; wb_ready = 1;
    drive_in('0, '0, 0, 0, 2'b00, 0, 2'b00, 0, 5'd0);
    repeat (2) @(negedge clk);
    chk("rst_valid", ls_valid, 0);
    chk("rst_req", bus.dmem_req, 0);
    chk("rst_we", bus.dmem_we, 0);
    chk("rst_wstrb", bus.dmem_wstrb, 0);
    chk("rst_mis", ls_misalign, 0);
    chk("rst_exu", exu_res_o, 0);
    chk("rst_rddata", ls_rd_data, 0);
    chk("rst_ready", ls_ready, 1);
    @(posedge clk); #1 rst = 1;

    // ALU op, 1-cycle latency
    send(64'h1234, '0, 0, 0, 2'b11, 0, 2'b10, 1, 5'd5, '0, 0);
    @(negedge clk);
    chk("alu_latency", ls_valid, 1);
    wait_drain();

    // 4 back-to-back ALU ops
    max_run = 0; run = 0;
    for (int i = 1; i <= 4; i++)
      send(64'h10 * i, '0, 0, 0, 2'b11, 0, 2'b10, 1, 5'(i), '0, 0);
    wait_drain();
    repeat (2) @(negedge clk);
    chk("burst_run", max_run, 4);

    // loads
    mem_op("lb", 64'h8000_0003, '0, 1, 0, 2'b00, 0, 0, 2, 64'h0000_0000_8000_0000,
           64'hFFFF_FFFF_FFFF_FF80, 8'h00, '0, 0, 1);
    mem_op("lbu", 64'h8000_0003, '0, 1, 0, 2'b00, 1, 0, 2, 64'h0000_0000_8000_0000,
           64'h80, 8'h00, '0, 0, 1);
    mem_op("lh", 64'h8000_0016, '0, 1, 0, 2'b01, 0, 0, 1, R,
           64'hFFFF_FFFF_FFFF_8899, 8'h00, '0, 0, 1);
    mem_op("lhu", 64'h8000_0022, '0, 1, 0, 2'b01, 1, 1, 1, R,
           64'hCCDD, 8'h00, '0, 0, 2);
    mem_op("lw", 64'h8000_0030, '0, 1, 0, 2'b10, 0, 0, 3, R,
           64'hFFFF_FFFF_CCDD_EEFF, 8'h00, '0, 0, 1);
    mem_op("lwu", 64'h8000_0034, '0, 1, 0, 2'b10, 1, 0, 1, R,
           64'h8899_AABB, 8'h00, '0, 0, 1);
    mem_op("ld", 64'h8000_0048, '0, 1, 0, 2'b11, 1, 0, 1, R,
           R, 8'h00, '0, 0, 1);
    mem_op("lbu5", 64'h8000_0055, '0, 1, 0, 2'b00, 1, 0, 1, R,
           64'hAA, 8'h00, '0, 0, 1);
    mem_op("ldst_both", 64'h8000_0060, 64'h1, 1, 1, 2'b11, 0, 0, 1, R,
           R, 8'h00, '0, 0, 1);

    // stores
    mem_op("sh", 64'h8000_0106, 64'hABCD, 0, 1, 2'b01, 0, 3, 1, '0,
           '0, 8'hC0, 64'hABCD_0000_0000_0000, 0, 4);
    mem_op("sb", 64'h8000_0111, 64'h1111_2222_3333_44A5, 0, 1, 2'b00, 0, 0, 1, '0,
           '0, 8'h02, 64'h1122_2233_3344_A500, 0, 1);
    mem_op("sw", 64'h8000_0124, 64'h1122_3344, 0, 1, 2'b10, 0, 1, 1, '0,
           '0, 8'hF0, 64'h1122_3344_0000_0000, 0, 2);
    mem_op("sd", 64'h8000_0138, R, 0, 1, 2'b11, 0, 0, 1, '0,
           '0, 8'hFF, R, 0, 1);

    // misaligned: no bus request, flagged, rd_ena cleared
    mem_op("lw_mis", 64'h8000_0202, '0, 1, 0, 2'b10, 0, 0, 1, R,
           '0, 8'h00, '0, 1, 0);
    mem_op("lh_mis", 64'h8000_0211, '0, 1, 0, 2'b01, 0, 0, 1, R,
           '0, 8'h00, '0, 1, 0);
    mem_op("sd_mis", 64'h8000_0224, R, 0, 1, 2'b11, 0, 0, 1, '0,
           '0, 8'h00, '0, 1, 0);

    // back-pressure on a load result
    wb_ready = 0;
    mem_rdata = R; gnt_dly = 0; rv_dly = 1;
    send(64'h8000_0300, '0, 1, 0, 2'b11, 0, 2'b01, 1, 5'd8, R, 0);
    n = 0;
    while (!ls_valid && n < 50) begin
      @(negedge clk); n++;
    end
    chk("stall_valid_seen", ls_valid, 1);
    drive_in(64'h77, '0, 0, 0, 2'b11, 0, 2'b10, 1, 5'd9);
    ex_valid = 1;
    repeat (5) begin
      chk("stall_ready", ls_ready, 0);
      chk("stall_valid", ls_valid, 1);
      chk("stall_rd", ls_rd_data, R);
      chk("stall_exu", exu_res_o, 64'h8000_0300);
      @(negedge clk);
    end
    @(posedge clk); #1;
    wb_ready = 1;
    #1;
    chk("stall_accept", ls_ready, 1);
    q.push_back(mk(64'h77, 2'b10, 1, 5'd9, '0, 0));
    @(posedge clk); #1;
    ex_valid = 0;
    pc_n = pc_n + 4;
    wait_drain();

    // reset while waiting for rvalid
    gnt_dly = 0; rv_dly = 1000;
    send(64'h8000_0400, '0, 1, 0, 2'b10, 0, 2'b01, 1, 5'd10, '0, 0);
    @(posedge clk); #1;
    chk("wait_ready", ls_ready, 0);
    chk("wait_req", bus.dmem_req, 0);
    #2 rst = 0;
    #1;
    chk("rst_mid_valid", ls_valid, 0);
    chk("rst_mid_req", bus.dmem_req, 0);
    chk("rst_mid_ready", ls_ready, 1);
    q.delete();
    rv_dly = 1;
    @(posedge clk); #1 rst = 1;
    #2 force_rv = 1;
    @(posedge clk); #3 force_rv = 0;
    repeat (3) begin
      @(negedge clk);
      chk("late_rv_valid", ls_valid, 0);
      chk("late_rv_idle", ls_ready, 1);
    end
    send(64'h5555, '0, 0, 0, 2'b11, 0, 2'b10, 1, 5'd11, '0, 0);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
